seq_pattern_detector: RTL and testbench

- Parametrised serial bit-pattern detector, successor to the fixed-sequence detector FSMs in the serial-protocol front end.
- Pattern, length and overlap mode are run-time programmable through a config-load strobe.
- Raises a registered one-cycle match pulse when the programmed pattern is seen.
- Keeps a saturating match counter; the stream is sampled only while enabled.

---
 rtl/seq_det_pkg.sv | 35 +++
 rtl/seq_pattern_detector_pattern_window.sv | 74 +++++++
 rtl/seq_pattern_detector.sv | 130 +++++++++++++
 tb/tb_seq_pattern_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the serial pattern detector
//
// Purpose: detector state encoding, minimum legal pattern length,
//          a length-legality check and a low-bit mask builder.
// Ports:   none (package).

package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    HIT   = 2'd2
  } det_state_e;

  localparam int unsigned MIN_LEN = 2;

  // Width of the mask returned by len_mask; covers the largest legal MAX_LEN.
  localparam int unsigned MASK_W = 32;

  function automatic logic len_is_legal(input int unsigned len,
                                        input int unsigned max_len);
    return (len >= MIN_LEN) && (len <= max_len);
  endfunction

  // Mask with the low 'len' bits set.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_pattern_window.sv
// rtl/seq_pattern_detector_pattern_window.sv - history shift register, fill counter and masked compare
//
// Purpose: tracks the most recent serial bits and how many valid bits are held,
//          and flags when the bit being sampled completes the pattern.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         drop history and fill (configuration reload)
//   shift_en      sample x on this edge
//   x             serial data bit
//   overlap       1 = keep fill after a hit, 0 = restart fill after a hit
//   pat, len      latched pattern and its length
//   hit_next      this edge's sample completes a match

module pattern_window
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               x,
  input  logic               overlap,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit_next
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MASK_W-1:0]  mask_full;
  logic [MASK_W-1:0]  diff_full;
  logic               pattern_eq;

  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], x};
    fill_inc   = (fill_q >= len) ? len : fill_q + LEN_W'(1);

    // Compare at full mask width so every mask bit participates; bits above
    // MAX_LEN are zero on both sides of the XOR.
    mask_full  = len_mask(32'(len));
    diff_full  = MASK_W'(hist_shift ^ pat);
    pattern_eq = ((diff_full & mask_full) == '0);

    hit_next   = shift_en && (fill_inc == len) && pattern_eq;

    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      // Non-overlapping mode needs len fresh bits before the next match.
      fill_d = (hit_next && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector
//
// Purpose: detects a run-time programmed serial pattern, pulses match for one
//          cycle per detection and keeps a saturating match count.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cfg_load      strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern   pattern, bit cfg_len-1 arrives first
//   cfg_len       pattern length (MIN_LEN..MAX_LEN legal)
//   cfg_overlap   1 = overlapping matches allowed
//   en            sample x on this edge
//   x             serial data bit
//   count_clr     synchronous clear of match_count
//   match         one-cycle registered match pulse
//   match_count   saturating match count
//   armed         a legal configuration is loaded
//   cfg_err       last cfg_load had an illegal length

module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               en,
  input  logic               x,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  det_state_e         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               cfg_legal;
  logic               shift_en;
  logic               hit_next;
  logic [CNT_W-1:0]   count_base;

  // A config load wins over sampling; the x bit on that edge is dropped.
  assign cfg_legal = len_is_legal(32'(cfg_len), MAX_LEN);
  assign shift_en  = en && !cfg_load && (state_q != UNCFG);

  pattern_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clear    (cfg_load),
    .shift_en (shift_en),
    .x        (x),
    .overlap  (ovl_q),
    .pat      (pat_q),
    .len      (len_q),
    .hit_next (hit_next)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cfg_err_d = cfg_err_q;

    if (cfg_load) begin
      if (cfg_legal) begin
        pat_d     = cfg_pattern;
        len_d     = cfg_len;
        ovl_d     = cfg_overlap;
        cfg_err_d = 1'b0;
        state_d   = HUNT;
      end else begin
        pat_d     = '0;
        len_d     = '0;
        ovl_d     = 1'b0;
        cfg_err_d = 1'b1;
        state_d   = UNCFG;
      end
    end else begin
      unique case (state_q)
        UNCFG:     state_d = UNCFG;
        // hit_next is already gated by en, so en=0 falls back to HUNT.
        HUNT, HIT: state_d = hit_next ? HIT : HUNT;
        default:   state_d = UNCFG;
      endcase
    end

    // Clear first, then count the match on top of it.
    count_base = count_clr ? '0 : count_q;
    count_d    = (hit_next && (count_base != '1)) ? count_base + CNT_W'(1) : count_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UNCFG;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
    end
  end

  assign match       = (state_q == HIT);
  assign armed       = (state_q != UNCFG);
  assign match_count = count_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - scoreboard bench for seq_pattern_detector

module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               en;
  logic               x;
  logic               count_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .en          (en),
    .x           (x),
    .count_clr   (count_clr),
    .match       (match),
    .match_count (match_count),
    .armed       (armed),
    .cfg_err     (cfg_err)
  );

  typedef struct {
    bit match;
    int count;
    bit armed;
    bit err;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // Reference model state
  bit          m_armed, m_err, m_ovl, m_match;
  int unsigned m_pat, m_len, m_hist, m_fill, m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_err = 0; m_ovl = 0; m_match = 0;
    m_pat = 0; m_len = 0; m_hist = 0; m_fill = 0; m_count = 0;
  endtask

  task automatic model_step(input bit load, input int unsigned pat, input int unsigned len,
                            input bit ovl, input bit e, input bit xb, input bit clr);
    if (clr) m_count = 0;
    m_match = 0;
    if (load) begin
      if (len >= 2 && len <= MAX_LEN) begin
        m_armed = 1; m_err = 0; m_pat = pat; m_len = len; m_ovl = ovl;
      end else begin
        m_armed = 0; m_err = 1; m_pat = 0; m_len = 0; m_ovl = 0;
      end
      m_hist = 0;
      m_fill = 0;
    end else if (m_armed && e) begin
      m_hist = ((m_hist << 1) | xb) & ((1 << MAX_LEN) - 1);
      m_fill = (m_fill < m_len) ? m_fill + 1 : m_len;
      if (m_fill == m_len && ((m_hist ^ m_pat) & ((1 << m_len) - 1)) == 0) begin
        m_match = 1;
        if (m_count < CNT_MAX) m_count++;
        if (!m_ovl) m_fill = 0;
      end
    end
  endtask

  task automatic step(input bit load, input int unsigned pat, input int unsigned len,
                      input bit ovl, input bit e, input bit xb, input bit clr);
    exp_t ex;
    exp_t got;
    cfg_load    = load;
    cfg_pattern = MAX_LEN'(pat);
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    en          = e;
    x           = xb;
    count_clr   = clr;
    model_step(load, pat, len, ovl, e, xb, clr);
    ex.match = m_match; ex.count = int'(m_count); ex.armed = m_armed; ex.err = m_err;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    step_no++;
    got = sb_q.pop_front();
    check($sformatf("match@%0d", step_no), 32'(match), 32'(got.match));
    check($sformatf("count@%0d", step_no), 32'(match_count), 32'(got.count));
    check($sformatf("armed@%0d", step_no), 32'(armed), 32'(got.armed));
    check($sformatf("cfg_err@%0d", step_no), 32'(cfg_err), 32'(got.err));
  endtask

  task automatic load_cfg(input int unsigned pat, input int unsigned len, input bit ovl);
    step(1'b1, pat, len, ovl, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b0, 0, 0, 1'b0, 1'b1, s[i] == "1", 1'b0);
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    en = 0; x = 0; count_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_match", 32'(match), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;

    // Unconfigured: x ignored
    stream("1111");

    // 6-bit pattern, single match
    load_cfg(32'b101100, 6, 1'b1);
    stream("101100");
    idle();
    check("cnt_6bit", 32'(match_count), 1);

    // Overlap vs non-overlap
    load_cfg(32'b1011, 4, 1'b1);
    stream("1011011");
    check("cnt_ovl", 32'(match_count), 2);
    load_cfg(32'b1011, 4, 1'b0);
    stream("1011011");
    check("cnt_novl", 32'(match_count), 1);

    // Back-to-back matches, match held high
    load_cfg(32'b11, 2, 1'b1);
    stream("1111");
    check("cnt_11", 32'(match_count), 3);

    // en toggling: history frozen, match drops
    load_cfg(32'b11, 2, 1'b1);
    stream("1");
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream("1");
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream("1");
    check("cnt_en", 32'(match_count), 2);

    // Illegal lengths
    load_cfg(32'b00, 0, 1'b1);
    check("err_len0", 32'(cfg_err), 1);
    stream("00000000");
    load_cfg(32'h00, MAX_LEN + 1, 1'b1);
    check("armed_len9", 32'(armed), 0);
    stream("00000000");
    load_cfg(32'b10, 2, 1'b0);
    check("err_cleared", 32'(cfg_err), 0);
    stream("1010");

    // Saturation and clear coincident with a match
    load_cfg(32'b11, 2, 1'b1);
    stream("111111");
    check("cnt_sat", 32'(match_count), CNT_MAX);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("cnt_clr_hit", 32'(match_count), 1);

    // Reset while in HIT
    load_cfg(32'b11, 2, 1'b1);
    stream("11");
    check("pre_rst_match", 32'(match), 1);
    rst = 1'b1;
    #1;
    check("arst_match", 32'(match), 0);
    check("arst_count", 32'(match_count), 0);
    check("arst_armed", 32'(armed), 0);
    check("arst_err", 32'(cfg_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    stream("1111");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
